// File: rtl/red_pitaya_iq_sweep_sequencer_if.sv
// Result handshake between the sweep sequencer and the readout path.
// The sequencer drives the integrated pair; the readout returns ready.
interface red_pitaya_iq_sweep_sequencer_if #(
    parameter int ACCBITS = 48
) ();
    logic signed [ACCBITS-1:0] acc1_o;
    logic signed [ACCBITS-1:0] acc2_o;
    logic        [15:0]        point_idx_o;
    logic                      valid_o;
    logic                      ready_i;

    modport master (
        output acc1_o,
        output acc2_o,
        output point_idx_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  acc1_o,
        input  acc2_o,
        input  point_idx_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/red_pitaya_iq_sweep_sequencer.sv
// Network-analyzer sweep sequencer: steps the NCO, waits for settling,
// integrates both demodulator outputs and hands each point to readout.
module red_pitaya_iq_sweep_sequencer #(
    parameter int OUTBITS   = 18,
    parameter int ACCBITS   = 48,
    parameter int PHASEBITS = 32,
    parameter int CNTBITS   = 32
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic        [PHASEBITS-1:0] freq_start_i,
    input  logic        [PHASEBITS-1:0] freq_step_i,
    input  logic        [15:0]          points_i,
    input  logic        [CNTBITS-1:0]   settle_i,
    input  logic        [CNTBITS-1:0]   avg_i,
    input  logic signed [OUTBITS-1:0]   demod1_i,
    input  logic signed [OUTBITS-1:0]   demod2_i,
    red_pitaya_iq_sweep_sequencer_if.master res,
    output logic        [PHASEBITS-1:0] phase_inc_o,
    output logic                        phase_rst_o,
    output logic                        busy_o,
    output logic                        done_o
);
    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, ACQ, OUT, DONE
    } state_t;

    state_t                     state;
    logic        [PHASEBITS-1:0] freq;
    logic        [PHASEBITS-1:0] step;
    logic        [15:0]          last;
    logic        [15:0]          idx;
    logic        [CNTBITS-1:0]   settle;
    logic        [CNTBITS-1:0]   avg;
    logic        [CNTBITS-1:0]   cnt;
    logic signed [ACCBITS-1:0]   acc1;
    logic signed [ACCBITS-1:0]   acc2;
    logic                        valid;
    logic signed [ACCBITS-1:0]   d1x;
    logic signed [ACCBITS-1:0]   d2x;

    assign d1x = {{(ACCBITS-OUTBITS){demod1_i[OUTBITS-1]}}, demod1_i};
    assign d2x = {{(ACCBITS-OUTBITS){demod2_i[OUTBITS-1]}}, demod2_i};

    assign res.acc1_o      = acc1;
    assign res.acc2_o      = acc2;
    assign res.point_idx_o = idx;
    assign res.valid_o     = valid;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            freq        <= '0;
            step        <= '0;
            last        <= '0;
            idx         <= '0;
            settle      <= '0;
            avg         <= '0;
            cnt         <= '0;
            acc1        <= '0;
            acc2        <= '0;
            valid       <= 1'b0;
            phase_inc_o <= '0;
            phase_rst_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (abort_i && state != IDLE) begin
            // abort wins over a same-cycle handshake
            state       <= IDLE;
            valid       <= 1'b0;
            phase_rst_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        freq        <= freq_start_i;
                        step        <= freq_step_i;
                        last        <= (points_i == '0) ? '0 : points_i - 16'd1;
                        settle      <= settle_i;
                        avg         <= (avg_i == '0) ? CNTBITS'(1) : avg_i;
                        idx         <= '0;
                        busy_o      <= 1'b1;
                        phase_rst_o <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    phase_inc_o <= freq;
                    phase_rst_o <= 1'b0;
                    if (settle == '0) begin
                        cnt   <= avg;
                        acc1  <= '0;
                        acc2  <= '0;
                        state <= ACQ;
                    end else begin
                        cnt   <= settle;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNTBITS'(1)) begin
                        cnt   <= avg;
                        acc1  <= '0;
                        acc2  <= '0;
                        state <= ACQ;
                    end else begin
                        cnt <= cnt - CNTBITS'(1);
                    end
                end
                ACQ: begin
                    acc1 <= acc1 + d1x;
                    acc2 <= acc2 + d2x;
                    if (cnt == CNTBITS'(1)) begin
                        valid <= 1'b1;
                        state <= OUT;
                    end else begin
                        cnt <= cnt - CNTBITS'(1);
                    end
                end
                OUT: begin
                    if (valid && res.ready_i) begin
                        valid <= 1'b0;
                        if (idx == last) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + 16'd1;
                            freq  <= freq + step;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_red_pitaya_iq_sweep_sequencer.sv
// Bench for the IQ sweep sequencer: timeline model checked every cycle,
// plus literal expectations on captured handshakes.
module tb_red_pitaya_iq_sweep_sequencer;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic        [31:0] fs = '0;
    logic        [31:0] fstep = '0;
    logic        [15:0] pts = '0;
    logic        [31:0] settle = '0;
    logic        [31:0] avg = '0;
    logic signed [17:0] d1 = '0;
    logic signed [17:0] d2 = '0;
    logic        [31:0] phase;
    logic               prst;
    logic               busy;
    logic               done;
    bit                 ramp = 1'b0;
    bit                 cmp_en = 1'b0;
    int                 checks = 0;
    int                 errors = 0;

    red_pitaya_iq_sweep_sequencer_if #(.ACCBITS(48)) rif ();

    red_pitaya_iq_sweep_sequencer dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .abort_i      (abort),
        .freq_start_i (fs),
        .freq_step_i  (fstep),
        .points_i     (pts),
        .settle_i     (settle),
        .avg_i        (avg),
        .demod1_i     (d1),
        .demod2_i     (d2),
        .res          (rif),
        .phase_inc_o  (phase),
        .phase_rst_o  (prst),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int                 n = 0;
    logic signed [47:0] h1 [256];
    logic signed [47:0] h2 [256];
    bit                 m_act = 0, m_indone = 0, m_accchk = 1;
    int                 ps, m_s, m_a, m_last;
    logic        [31:0] m_freq, m_step;
    logic        [31:0] e_phase = '0;
    logic        [15:0] e_idx = '0;
    logic               e_valid = 0, e_busy = 0, e_done = 0, e_rst = 0;
    logic signed [47:0] e_a1 = '0, e_a2 = '0;

    always @(posedge clk) begin
        n++;
        h1[8'(n)] = d1;
        h2[8'(n)] = d2;
        if (!rstn) begin
            m_act = 0; m_indone = 0; m_accchk = 1;
            e_phase = '0; e_idx = '0; e_valid = 0; e_busy = 0;
            e_done = 0; e_rst = 0; e_a1 = '0; e_a2 = '0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1; m_indone = 0; m_accchk = 0;
                m_s = int'(settle);
                m_a = (avg == 0) ? 1 : int'(avg);
                m_last = (pts == 0) ? 0 : int'(pts) - 1;
                m_freq = fs; m_step = fstep;
                e_idx = '0; ps = n; e_busy = 1; e_rst = 1;
            end
        end else if (abort) begin
            m_act = 0; e_valid = 0; e_busy = 0; e_done = 0; e_rst = 0;
        end else if (m_indone) begin
            m_act = 0; e_done = 0; e_busy = 0;
        end else begin
            if (n == ps + 1) begin
                e_phase = m_freq;
                e_rst = 0;
            end
            if (n == ps + 1 + m_s + m_a) begin
                e_valid = 1; e_a1 = '0; e_a2 = '0;
                for (int k = 0; k < m_a; k++) begin
                    e_a1 += h1[8'(n - k)];
                    e_a2 += h2[8'(n - k)];
                end
            end else if (e_valid && rif.ready_i) begin
                e_valid = 0;
                if (int'(e_idx) == m_last) begin
                    e_done = 1; m_indone = 1;
                end else begin
                    e_idx++; m_freq += m_step; ps = n;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", rif.valid_o, e_valid);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("phase_rst", prst, e_rst);
            chk("phase_inc", phase, e_phase);
            chk("point_idx", rif.point_idx_o, e_idx);
            if (e_valid || m_accchk) begin
                chk("acc1", rif.acc1_o, e_a1);
                chk("acc2", rif.acc2_o, e_a2);
            end
        end
    end

    // ---------------- handshake monitor ----------------
    typedef struct {
        logic        [31:0] ph;
        logic        [15:0] idx;
        logic signed [47:0] a1;
        logic signed [47:0] a2;
        int                 e;
    } cap_t;
    cap_t caps[$];
    int   me = 0, brise = -1, vrise = -1, done_cnt = 0, done_e = -1;
    logic bprev = 0, vprev = 0, dprev = 0;

    always @(posedge clk) begin
        me++;
        if (busy === 1'b1 && bprev !== 1'b1 && brise < 0) brise = me - 1;
        if (rif.valid_o === 1'b1 && vprev !== 1'b1 && vrise < 0) vrise = me - 1;
        if (done === 1'b1 && dprev !== 1'b1) begin
            done_cnt++;
            done_e = me;
        end
        bprev = busy; vprev = rif.valid_o; dprev = done;
        if (rstn && !abort && rif.valid_o === 1'b1 && rif.ready_i)
            caps.push_back('{phase, rif.point_idx_o, rif.acc1_o, rif.acc2_o, me});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (ramp) begin
            d1 = d1 + 18'sd37;
            d2 = d2 - 18'sd1021;
        end
    endtask

    task automatic start_sweep(input logic [31:0] f0, input logic [31:0] st,
                               input logic [15:0] p, input logic [31:0] s,
                               input logic [31:0] a);
        caps.delete();
        brise = -1; vrise = -1;
        fs = f0; fstep = st; pts = p; settle = s; avg = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        fs = 32'hDEAD_BEEF; fstep = 32'h1234; pts = 16'd9;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk(nm, busy, 1'b0);
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int k = 0;
        while (!rif.valid_o && k < budget) begin
            tick();
            k++;
        end
        chk(nm, rif.valid_o, 1'b1);
    endtask

    initial begin
        logic signed [47:0] s1, s2;
        logic        [15:0] si;
        int                 dc;
        rif.ready_i = 1'b0;
        cmp_en = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        rstn = 1'b1;
        tick();
        chk("reset busy", busy, 0);
        chk("reset phase", phase, 0);
        chk("reset acc1", rif.acc1_o, 0);

        // basic sweep with ignored start while busy
        rif.ready_i = 1'b1; d1 = 18'sd100; d2 = -18'sd50;
        dc = done_cnt;
        start_sweep(1000, 500, 3, 4, 8);
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(200, "basic idle");
        chk("basic n", caps.size(), 3);
        if (caps.size() == 3) begin
            chk("basic ph0", caps[0].ph, 1000);
            chk("basic ph1", caps[1].ph, 1500);
            chk("basic ph2", caps[2].ph, 2000);
            chk("basic idx2", caps[2].idx, 2);
            chk("basic acc1", caps[1].a1, 800);
            chk("basic acc2", caps[2].a2, -400);
            chk("basic done time", done_e, caps[2].e + 1);
        end
        chk("basic valid time", vrise - brise, 13);
        chk("basic done cnt", done_cnt - dc, 1);
        chk("basic phase held", phase, 2000);

        // backpressure
        rif.ready_i = 1'b0; ramp = 1'b1;
        start_sweep(32'h100, 32'h10, 2, 2, 5);
        wait_valid(50, "bp valid");
        s1 = rif.acc1_o; s2 = rif.acc2_o; si = rif.point_idx_o;
        repeat (20) tick();
        chk("bp hold valid", rif.valid_o, 1);
        chk("bp hold acc1", rif.acc1_o, s1);
        chk("bp hold acc2", rif.acc2_o, s2);
        chk("bp hold idx", rif.point_idx_o, si);
        rif.ready_i = 1'b1;
        tick();
        chk("bp resume", rif.valid_o, 0);
        chk("bp resume n", caps.size(), 1);
        wait_idle(100, "bp idle");
        chk("bp n", caps.size(), 2);
        ramp = 1'b0;

        // edge values
        d1 = 18'sd5; d2 = 18'sd9;
        start_sweep(7, 3, 0, 0, 0);
        wait_idle(50, "edge idle");
        chk("edge n", caps.size(), 1);
        if (caps.size() == 1) begin
            chk("edge acc1", caps[0].a1, 5);
            chk("edge acc2", caps[0].a2, 9);
            chk("edge ph", caps[0].ph, 7);
        end
        chk("edge valid time", vrise - brise, 2);

        // phase and accumulator wrap
        d1 = -18'sd131072; d2 = 18'sd131071;
        start_sweep(32'hFFFF_FF00, 32'h200, 2, 1, 4);
        wait_idle(100, "wrap idle");
        chk("wrap n", caps.size(), 2);
        if (caps.size() == 2) begin
            chk("wrap ph0", caps[0].ph, 32'hFFFF_FF00);
            chk("wrap ph1", caps[1].ph, 32'h0000_0100);
            chk("wrap acc1", caps[0].a1, -524288);
            chk("wrap acc2", caps[1].a2, 524284);
        end

        // abort in ACQ
        d1 = 18'sd11; dc = done_cnt;
        start_sweep(0, 1, 2, 3, 10);
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort acq valid", rif.valid_o, 0);
        chk("abort acq busy", busy, 0);
        repeat (3) tick();
        chk("abort acq done", done_cnt - dc, 0);
        chk("abort acq n", caps.size(), 0);

        // abort coincident with handshake
        rif.ready_i = 1'b0;
        start_sweep(5, 5, 2, 0, 2);
        wait_valid(20, "abort hs valid");
        abort = 1'b1; rif.ready_i = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort hs valid", rif.valid_o, 0);
        chk("abort hs busy", busy, 0);
        chk("abort hs idx", rif.point_idx_o, 0);
        repeat (3) tick();
        chk("abort hs n", caps.size(), 0);
        chk("abort hs done", done_cnt - dc, 0);

        // restart after abort
        d1 = 18'sd1; d2 = -18'sd1;
        start_sweep(42, 0, 1, 0, 3);
        wait_idle(50, "restart idle");
        chk("restart n", caps.size(), 1);
        if (caps.size() == 1) begin
            chk("restart acc1", caps[0].a1, 3);
            chk("restart acc2", caps[0].a2, -3);
            chk("restart ph", caps[0].ph, 42);
        end

        // reset mid-SETTLE
        start_sweep(99, 1, 2, 20, 2);
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        chk("rst phase", phase, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", rif.valid_o, 0);
        chk("rst idx", rif.point_idx_o, 0);
        chk("rst acc1", rif.acc1_o, 0);
        chk("rst prst", prst, 0);
        rstn = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
